// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, synchronized row sampling, per-frame
// classification and a debounce FSM that emits one pulse per accepted press.
module keypad_scan #(
  parameter int unsigned COL_TICKS       = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_pressed_o
);

  localparam int unsigned SlotW = $clog2(COL_TICKS);
  localparam int unsigned CntW  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(COL_TICKS - 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_FRAMES);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

  logic [SlotW-1:0] slot;
  logic [1:0]       col;
  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [15:0]      frame;
  logic             frame_done;

  state_e          state;
  logic [3:0]      cand;
  logic [CntW-1:0] cnt;

  logic [4:0] n_down;
  logic [3:0] down_code;
  logic       is_none;
  logic       is_single;

  assign col_o = ~(4'b0001 << col);

  // Frame bit {row, col} is set when that key reads low in its column slot.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      slot       <= '0;
      col        <= 2'd0;
      row_meta   <= 4'hF;
      row_sync   <= 4'hF;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      row_meta   <= row_i;
      row_sync   <= row_meta;
      frame_done <= 1'b0;
      if (slot == SlotLast) begin
        slot <= '0;
        col  <= col + 2'd1;
        for (int r = 0; r < 4; r++) begin
          frame[{r[1:0], col}] <= ~row_sync[r];
        end
        frame_done <= (col == 2'd3);
      end else begin
        slot <= slot + SlotW'(1);
      end
    end
  end

  always_comb begin
    n_down    = '0;
    down_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        n_down    = n_down + 5'd1;
        down_code = 4'(i);
      end
    end
    is_none   = (n_down == 5'd0);
    is_single = (n_down == 5'd1);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state         <= StIdle;
      cand          <= '0;
      cnt           <= '0;
      key_code_o    <= '0;
      key_valid_o   <= 1'b0;
      key_pressed_o <= 1'b0;
    end else begin
      key_valid_o <= 1'b0;
      if (frame_done) begin
        unique case (state)
          StIdle: begin
            if (is_single) begin
              state <= StDebounce;
              cand  <= down_code;
              cnt   <= CntOne;
            end
          end
          StDebounce: begin
            if (is_single && down_code == cand) begin
              if (cnt >= CntMax - CntOne) begin
                state         <= StPressed;
                cnt           <= CntMax;
                key_code_o    <= cand;
                key_valid_o   <= 1'b1;
                key_pressed_o <= 1'b1;
              end else begin
                cnt <= cnt + CntOne;
              end
            end else begin
              state <= StIdle;
              cnt   <= '0;
            end
          end
          StPressed: begin
            if (is_none) begin
              state <= StRelease;
              cnt   <= CntOne;
            end
          end
          StRelease: begin
            if (is_none) begin
              if (cnt >= CntMax - CntOne) begin
                state         <= StIdle;
                cnt           <= '0;
                key_pressed_o <= 1'b0;
              end else begin
                cnt <= cnt + CntOne;
              end
            end else begin
              // Key came back before release was confirmed: resume the press silently.
              state <= StPressed;
              cnt   <= '0;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a frame-level keypad model queues expected
// pulses and press-level changes; a negedge monitor compares against the DUT.
module tb_keypad_scan;

  localparam int unsigned ColTicks  = 4;
  localparam int unsigned DebFrames = 2;
  localparam int          FrameLen  = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] mask = '0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  code;
  logic        valid;
  logic        pressed;

  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a held key sits on the driven-low column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row[r] = ~(|(mask[4*r +: 4] & ~col));
    end
  end

  keypad_scan #(
    .COL_TICKS      (ColTicks),
    .DEBOUNCE_FRAMES(DebFrames)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .row_i        (row),
    .col_o        (col),
    .key_code_o   (code),
    .key_valid_o  (valid),
    .key_pressed_o(pressed)
  );

  typedef struct {int t; logic [3:0] code;} pulse_t;
  typedef struct {int t; logic lvl;} lvl_t;

  pulse_t pq[$];
  lvl_t   lq[$];
  pulse_t p;

  int   checks = 0;
  int   failures = 0;
  int   n = 0;
  int   f = 0;
  bit   mon_en = 1'b0;
  logic [3:0] exp_code = '0;
  logic       exp_pressed = 1'b0;
  logic [3:0] exp_col;

  // Model state: press accepted, consecutive same-key run, consecutive empty run.
  bit held = 1'b0;
  int run_key = -1;
  int run_len = 0;
  int rel_len = 0;

  // Cycles since reset release; interval n has slot n%4 and column (n/4)%4.
  always @(posedge clk) n = rstn ? n + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at n=%0d: got %0h, want %0h", name, n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_col = 4'hF;
      exp_col[(n / 4) % 4] = 1'b0;
      check("col_o", col, exp_col);
      while (lq.size() > 0 && lq[0].t <= n) begin
        exp_pressed = lq[0].lvl;
        void'(lq.pop_front());
      end
      check("key_pressed_o", pressed, exp_pressed);
      if (valid) begin
        if (pq.size() == 0) begin
          check("unexpected key_valid_o", valid, 1'b0);
        end else begin
          p = pq.pop_front();
          check("pulse time", n, p.t);
          check("pulse code", code, p.code);
          exp_code = p.code;
        end
      end else if (pq.size() > 0 && pq[0].t < n) begin
        check("missed key_valid_o", valid, 1'b1);
        void'(pq.pop_front());
      end
      check("key_code_o", code, exp_code);
    end
  end

  // Hold one keypad pattern for a whole frame and queue the outputs it should cause.
  task automatic issue_frame(input logic [15:0] m);
    int k;
    int key;
    mask = m;
    k = $countones(m);
    key = -1;
    for (int i = 0; i < 16; i++) if (m[i]) key = i;
    if (!held) begin
      if (k == 1 && run_len > 0 && key == run_key) begin
        run_len++;
      end else if (k == 1 && run_len == 0) begin
        run_key = key;
        run_len = 1;
      end else begin
        run_len = 0;
      end
      if (run_len == DebFrames) begin
        held = 1'b1;
        run_len = 0;
        rel_len = 0;
        pq.push_back('{t: FrameLen * f + 17, code: 4'(key)});
        lq.push_back('{t: FrameLen * f + 17, lvl: 1'b1});
      end
    end else begin
      if (k == 0) begin
        rel_len++;
        if (rel_len == DebFrames) begin
          held = 1'b0;
          lq.push_back('{t: FrameLen * f + 17, lvl: 1'b0});
        end
      end else begin
        rel_len = 0;
      end
    end
    f++;
    repeat (FrameLen) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    mon_en = 1'b0;
    rstn = 1'b0;
    mask = '0;
    @(posedge clk);
    #1;
    held = 1'b0;
    run_len = 0;
    rel_len = 0;
    pq.delete();
    lq.delete();
    exp_code = '0;
    exp_pressed = 1'b0;
    check("reset col_o", col, 4'b1110);
    check("reset key_valid_o", valid, 1'b0);
    check("reset key_pressed_o", pressed, 1'b0);
    check("reset key_code_o", code, 4'h0);
    mon_en = 1'b1;
    repeat (cycles - 1) @(posedge clk);
    #1;
    rstn = 1'b1;
    f = 0;
  endtask

  initial begin
    int kind;
    int len;
    int a;
    int b;
    logic [15:0] m;

    do_reset(3);
    repeat (4) issue_frame(16'h0000);     // idle scan, 64 cycles
    repeat (4) issue_frame(16'h0200);     // row 2, col 1 -> code 9
    repeat (3) issue_frame(16'h0000);     // release, code must stay 9
    issue_frame(16'h0040);                // bounce on key 6
    issue_frame(16'h0000);
    repeat (3) issue_frame(16'h0040);
    repeat (3) issue_frame(16'h0000);
    repeat (4) issue_frame(16'h0021);     // keys 0 and 5 together
    issue_frame(16'h0000);

    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        m = 16'h0001 << $urandom_range(0, 15);
        len = $urandom_range(1, 4);
      end else if (kind <= 8) begin
        m = '0;
        len = $urandom_range(1, 3);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        m = (16'h0001 << a) | (16'h0001 << b);
        len = $urandom_range(1, 2);
      end
      repeat (len) issue_frame(m);
    end
    repeat (3) issue_frame(16'h0000);
    check("pending pulses", pq.size(), 0);
    check("pending level changes", lq.size(), 0);

    // One frame of key 5 reaches debounce, then a one-cycle reset mid-frame.
    issue_frame(16'h0020);
    repeat (4) @(posedge clk);
    #1;
    do_reset(1);
    repeat (4) issue_frame(16'h0000);
    check("pulses after reset", pq.size(), 0);
    check("pressed after reset", pressed, 1'b0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter COL_TICKS, default 50000, clock cycles per column time slot (0.5 ms at 100 MHz); SHALL be >= 4.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4, consecutive identical scan frames needed to accept a press or release; SHALL be >= 2.
REQ-003 clk_i  input  1  system clock; all logic is on its rising edge.
REQ-004 rstn_i  input  1  reset, synchronous, active-low.
REQ-005 row_i  input  4  keypad row lines, active-low, asynchronous to clk_i.
REQ-006 col_o  output  4  keypad column drive, one-hot active-low.
REQ-007 key_code_o  output  4  code of the accepted key, computed as row*4+col.
REQ-008 key_valid_o  output  1  one-cycle pulse when a debounced press is accepted.
REQ-009 key_pressed_o  output  1  level, high from press acceptance until release acceptance.

Function
REQ-010 row_i SHALL pass through a 2-flop synchronizer, and only the synchronized value SHALL be used.
REQ-011 Slot counter counts 0..COL_TICKS-1 and then wraps; on wrap the active column advances 0->1->2->3->0.
REQ-012 col_o SHALL drive low only the active column: col0 = 4'b1110, col1 = 4'b1101, col2 = 4'b1011, col3 = 4'b0111.
REQ-013 Rows SHALL be sampled only on the cycle where slot count = COL_TICKS-1, before the column advances.
REQ-014 A frame is the 4 samples for columns 0..3.
REQ-015 Frame classification, with a low row bit meaning "key down":
- NONE: no key down.
- SINGLE(K): exactly one key down.
- MULTI: two or more keys down.
REQ-016 frame_done SHALL be asserted one cycle after the column-3 sample, and the FSM SHALL update only on frame_done.
REQ-017 FSM states are IDLE, DEBOUNCE, PRESSED and RELEASE, holding a candidate code cand and a frame counter cnt.
REQ-018 IDLE: on SINGLE(K) -> DEBOUNCE with cand=K, cnt=1; on NONE or MULTI -> stay in IDLE.
REQ-019 DEBOUNCE: on SINGLE(cand), increment cnt; when cnt reaches DEBOUNCE_FRAMES -> PRESSED.
REQ-020 DEBOUNCE: on NONE, MULTI or SINGLE(other) -> IDLE with cnt=0, and no output change.
REQ-021 Entering PRESSED SHALL, in the same cycle:
- load key_code_o=cand
- pulse key_valid_o for exactly one cycle
- set key_pressed_o=1.
REQ-022 PRESSED: on NONE -> RELEASE with cnt=1; on SINGLE or MULTI -> stay in PRESSED (no new pulse, key_code_o held).
REQ-023 RELEASE: on NONE, increment cnt; when cnt reaches DEBOUNCE_FRAMES -> IDLE with key_pressed_o=0.
REQ-024 RELEASE: on SINGLE or MULTI -> PRESSED with cnt=0, and no new key_valid_o pulse.
REQ-025 key_code_o SHALL hold its last accepted value after release and change only on a new acceptance.
REQ-026 Counters SHALL saturate at DEBOUNCE_FRAMES and never wrap; the slot counter width is $clog2(COL_TICKS).
REQ-027 Press-acceptance latency SHALL be exactly DEBOUNCE_FRAMES frames from the first frame that sees the key, plus 1 cycle for frame_done.
REQ-028 A key held indefinitely SHALL produce exactly one key_valid_o pulse (no auto-repeat).

Reset
REQ-029 While rstn_i=0 at a clock edge, the next-state values SHALL be:
- slot counter=0, column=0, col_o=4'b1110
- synchronizer flops=4'b1111
- FSM=IDLE, cand=0, cnt=0
- key_code_o=0, key_valid_o=0, key_pressed_o=0.
REQ-030 Reset asserted mid-frame or mid-debounce SHALL discard all partial frame and debounce state and SHALL produce no key_valid_o pulse.
REQ-031 After reset release, scanning SHALL restart at column 0, slot count 0.

Verification (COL_TICKS=4, DEBOUNCE_FRAMES=2, frame = 16 cycles)
REQ-032 Idle scan: row_i=4'hF for 64 cycles -> col_o cycles 1110,1101,1011,0111 with 4 cycles per column; key_valid_o never asserts.
REQ-033 Press row 2, col 1 (row_i[2]=0 only while col_o=1101), held for 4 frames -> exactly one key_valid_o pulse, 1 cycle after the 2nd frame_done, with key_code_o=9 and key_pressed_o=1.
REQ-034 Bounce: key present for 1 frame, absent for 1 frame, present again for 2 frames -> a single pulse after the 2nd consecutive frame.
REQ-035 Release: after REQ-033, row_i=4'hF -> key_pressed_o falls 1 cycle after the 2nd NONE frame_done; key_code_o stays 9.
REQ-036 Two keys down (codes 0 and 5) starting from IDLE for 4 frames -> no pulse; key_pressed_o stays 0.
REQ-037 Reset pulsed for 1 cycle during the DEBOUNCE state -> all outputs at reset values, col_o=1110 on the next cycle, and no pulse follows.
